// File: rtl/phy_sram_boot_arb_if.sv
// Signal bundle around the PHY SRAM boot/arbitration block: boot control,
// ROM read port, SRAM port and the two requester ports (A = firmware, B = debug).
interface phy_sram_boot_arb_if #(
    parameter int WD = 16,
    parameter int PW = 15
);
    logic          boot_start, boot_busy, boot_done;
    logic [PW-1:0] rom_addr;
    logic [WD-1:0] rom_rd_data;
    logic [PW-1:0] sram_addr;
    logic [WD-1:0] sram_wr_data, sram_rd_data;
    logic          sram_wr_en, sram_rd_en;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [PW-1:0] a_addr;
    logic [WD-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [PW-1:0] b_addr;
    logic [WD-1:0] b_wdata, b_rdata;

    modport slave (
        input  boot_start, rom_rd_data, sram_rd_data,
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output boot_busy, boot_done, rom_addr,
        output sram_addr, sram_wr_data, sram_wr_en, sram_rd_en,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );

    modport master (
        output boot_start, rom_rd_data, sram_rd_data,
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  boot_busy, boot_done, rom_addr,
        input  sram_addr, sram_wr_data, sram_wr_en, sram_rd_en,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/phy_sram_boot_arb.sv
// PHY firmware SRAM sequencer: copies the boot image ROM->SRAM on request, then
// round-robin arbitrates the single SRAM port between firmware (A) and debug (B).
module phy_sram_boot_arb #(
    parameter int WD         = 16,
    parameter int PW         = 15,
    parameter int BOOT_WORDS = 1024
) (
    input  logic               phy_sram_clk,
    input  logic               phy_sram_rst,
    phy_sram_boot_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COPY, RUN} state_t;

    // One bit wider than the address so a full 2^PW image still terminates.
    localparam logic [PW:0] LAST = (PW+1)'(BOOT_WORDS);

    state_t        state;
    logic [PW:0]   cnt, cnt_inc;
    logic [PW-1:0] rom_addr, wr_addr;
    logic          wr_vld, busy, done, ptr, rd_pend, rd_own;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [PW-1:0] sram_addr;
    logic [WD-1:0] sram_wr_data;
    logic          sram_wr_en, sram_rd_en;

    assign cnt_inc = cnt + 1'b1;

    // ptr = 0 favours A, 1 favours B; only consulted when both request.
    assign a_gnt = (state == RUN) & bus.a_req & (~bus.b_req | ~ptr);
    assign b_gnt = (state == RUN) & bus.b_req & (~bus.a_req |  ptr);

    always_ff @(posedge phy_sram_clk or posedge phy_sram_rst) begin
        if (phy_sram_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rom_addr <= '0;
            wr_addr  <= '0;
            wr_vld   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ptr      <= 1'b0;
            rd_pend  <= 1'b0;
            rd_own   <= 1'b0;
        end else begin
            // Read return is independent of the FSM so a read granted alongside
            // a reload boot_start still completes.
            rd_pend <= (a_gnt & ~bus.a_we) | (b_gnt & ~bus.b_we);
            rd_own  <= b_gnt;
            if (a_gnt)      ptr <= 1'b1;
            else if (b_gnt) ptr <= 1'b0;

            case (state)
                IDLE, RUN: begin
                    if (bus.boot_start) begin
                        state    <= COPY;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cnt      <= '0;
                        rom_addr <= '0;
                        wr_vld   <= 1'b0;
                    end
                end
                COPY: begin
                    if (cnt == LAST) begin
                        state  <= RUN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        wr_vld <= 1'b0;
                    end else begin
                        // ROM data for rom_addr arrives next cycle; write it there.
                        wr_vld  <= 1'b1;
                        wr_addr <= rom_addr;
                        cnt     <= cnt_inc;
                        if (cnt_inc != LAST) rom_addr <= cnt_inc[PW-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sram_addr    = '0;
        sram_wr_data = '0;
        sram_wr_en   = 1'b0;
        sram_rd_en   = 1'b0;
        if (state == COPY && wr_vld) begin
            sram_addr    = wr_addr;
            sram_wr_data = bus.rom_rd_data;
            sram_wr_en   = 1'b1;
        end else if (a_gnt) begin
            sram_addr    = bus.a_addr;
            sram_wr_data = bus.a_wdata;
            sram_wr_en   = bus.a_we;
            sram_rd_en   = ~bus.a_we;
        end else if (b_gnt) begin
            sram_addr    = bus.b_addr;
            sram_wr_data = bus.b_wdata;
            sram_wr_en   = bus.b_we;
            sram_rd_en   = ~bus.b_we;
        end
    end

    assign a_rvalid = rd_pend & ~rd_own;
    assign b_rvalid = rd_pend &  rd_own;

    assign bus.boot_busy    = busy;
    assign bus.boot_done    = done;
    assign bus.rom_addr     = rom_addr;
    assign bus.sram_addr    = sram_addr;
    assign bus.sram_wr_data = sram_wr_data;
    assign bus.sram_wr_en   = sram_wr_en;
    assign bus.sram_rd_en   = sram_rd_en;
    assign bus.a_gnt        = a_gnt;
    assign bus.b_gnt        = b_gnt;
    assign bus.a_rvalid     = a_rvalid;
    assign bus.b_rvalid     = b_rvalid;
    assign bus.a_rdata      = a_rvalid ? bus.sram_rd_data : '0;
    assign bus.b_rdata      = b_rvalid ? bus.sram_rd_data : '0;
endmodule

// File: tb/tb_phy_sram_boot_arb.sv
// Bench for phy_sram_boot_arb: 4-word boot image on a 15-bit part plus a
// full-range 16-word image on a 4-bit part; ROM/SRAM behavioural models.
module tb_phy_sram_boot_arb;
    localparam int WD  = 16;
    localparam int PW  = 15;
    localparam int N   = 4;
    localparam int PW2 = 4;
    localparam int N2  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phy_sram_boot_arb_if #(.WD(WD), .PW(PW))  bus1();
    phy_sram_boot_arb_if #(.WD(WD), .PW(PW2)) bus2();

    phy_sram_boot_arb #(.WD(WD), .PW(PW), .BOOT_WORDS(N)) dut (
        .phy_sram_clk(clk), .phy_sram_rst(rst), .bus(bus1)
    );
    phy_sram_boot_arb #(.WD(WD), .PW(PW2), .BOOT_WORDS(N2)) dut2 (
        .phy_sram_clk(clk), .phy_sram_rst(rst), .bus(bus2)
    );

    // Synchronous ROM (ROM[i] = A000+i) and single-port SRAM models.
    logic [WD-1:0] mem1 [0:(1<<PW)-1];
    logic [WD-1:0] mem2 [0:(1<<PW2)-1];
    always @(posedge clk) begin
        bus1.rom_rd_data <= 16'hA000 + 16'(bus1.rom_addr);
        bus2.rom_rd_data <= 16'hA000 + 16'(bus2.rom_addr);
        if (bus1.sram_wr_en) mem1[bus1.sram_addr] <= bus1.sram_wr_data;
        if (bus1.sram_rd_en) bus1.sram_rd_data <= mem1[bus1.sram_addr];
        if (bus2.sram_wr_en) mem2[bus2.sram_addr] <= bus2.sram_wr_data;
        if (bus2.sram_rd_en) bus2.sram_rd_data <= mem2[bus2.sram_addr];
    end

    typedef struct {int cyc; logic [PW-1:0] addr; logic [WD-1:0] data;} wr_exp_t;
    typedef struct {int cyc; bit port_b; logic [WD-1:0] data;} rd_exp_t;
    typedef struct {
        logic ar, aw; logic [PW-1:0] aa; logic [WD-1:0] ad;
        logic br, bw; logic [PW-1:0] ba; logic [WD-1:0] bd;
        logic ga, gb;
    } vec_t;

    wr_exp_t       wq1[$], wq2[$];
    rd_exp_t       rq[$];
    logic [WD-1:0] shadow [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_copy(input int c);
        for (int i = 0; i < N; i++) begin
            wq1.push_back('{c + 2 + i, PW'(i), 16'hA000 + 16'(i)});
            shadow[i] = 16'hA000 + 16'(i);
        end
    endtask

    task automatic push_rd(input int c, input bit pb, input logic [WD-1:0] d);
        rq.push_back('{c, pb, d});
    endtask

    function automatic vec_t mkv(bit ar, bit aw, int aa, int ad, bit br, bit bw, int ba, int bd,
                                 bit ga, bit gb);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = PW'(aa); v.ad = WD'(ad);
        v.br = br; v.bw = bw; v.ba = PW'(ba); v.bd = WD'(bd);
        v.ga = ga; v.gb = gb;
        return v;
    endfunction

    // Scoreboard monitors: copy writes and read returns, sampled at negedge.
    always @(negedge clk) begin : mon1
        wr_exp_t e;
        rd_exp_t r;
        if (!rst) begin
            if (wq1.size() > 0 && wq1[0].cyc == cyc) begin
                e = wq1.pop_front();
                chk("copy_wr_en", bus1.sram_wr_en, 1);
                chk("copy_wr_addr", bus1.sram_addr, e.addr);
                chk("copy_wr_data", bus1.sram_wr_data, e.data);
                chk("copy_rd_en", bus1.sram_rd_en, 0);
            end else if (bus1.boot_busy) begin
                chk("copy_wr_gap", bus1.sram_wr_en, 0);
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                chk("a_rvalid", bus1.a_rvalid, !r.port_b);
                chk("b_rvalid", bus1.b_rvalid, r.port_b);
                chk("rdata", r.port_b ? bus1.b_rdata : bus1.a_rdata, r.data);
            end else if (bus1.a_rvalid || bus1.b_rvalid) begin
                chk("rvalid_spurious", {bus1.a_rvalid, bus1.b_rvalid}, 0);
            end
        end
    end

    always @(negedge clk) begin : mon2
        wr_exp_t e;
        if (!rst) begin
            if (wq2.size() > 0 && wq2[0].cyc == cyc) begin
                e = wq2.pop_front();
                chk("big_wr_en", bus2.sram_wr_en, 1);
                chk("big_wr_addr", bus2.sram_addr, e.addr);
                chk("big_wr_data", bus2.sram_wr_data, e.data);
            end else if (bus2.boot_busy) begin
                chk("big_wr_gap", bus2.sram_wr_en, 0);
            end
        end
    end

    initial begin
        vec_t vt[$];
        logic exp_we;
        int   c0;

        {bus1.boot_start, bus1.a_req, bus1.a_we, bus1.b_req, bus1.b_we} = '0;
        {bus1.a_addr, bus1.a_wdata, bus1.b_addr, bus1.b_wdata} = '0;
        {bus2.boot_start, bus2.a_req, bus2.a_we, bus2.b_req, bus2.b_we} = '0;
        {bus2.a_addr, bus2.a_wdata, bus2.b_addr, bus2.b_wdata} = '0;

        // Stimulus table: {A req,we,addr,wdata, B req,we,addr,wdata, expected gnt A,B}.
        vt.push_back(mkv(1,1,5,'h1234, 0,0,0,0,       1,0));
        vt.push_back(mkv(0,0,0,0,      1,0,5,0,       0,1));
        vt.push_back(mkv(0,0,0,0,      0,0,0,0,       0,0));
        vt.push_back(mkv(1,0,1,0,      1,0,2,0,       1,0));
        vt.push_back(mkv(1,0,1,0,      1,0,2,0,       0,1));
        vt.push_back(mkv(1,0,1,0,      1,0,2,0,       1,0));
        vt.push_back(mkv(1,0,1,0,      1,0,2,0,       0,1));
        vt.push_back(mkv(1,1,7,'h7777, 1,1,8,'h8888,  1,0));
        vt.push_back(mkv(1,0,1,0,      1,1,8,'h8888,  0,1));
        vt.push_back(mkv(1,0,1,0,      0,0,0,0,       1,0));
        vt.push_back(mkv(0,0,0,0,      1,0,7,0,       0,1));
        vt.push_back(mkv(1,0,8,0,      1,0,5,0,       1,0));
        vt.push_back(mkv(0,0,0,0,      1,0,5,0,       0,1));
        vt.push_back(mkv(0,0,0,0,      0,0,0,0,       0,0));

        // Reset state, with a request already pending.
        repeat (2) tick();
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = '0;
        #3;
        chk("rst_busy", bus1.boot_busy, 0);
        chk("rst_done", bus1.boot_done, 0);
        chk("rst_a_gnt", bus1.a_gnt, 0);
        chk("rst_rom_addr", bus1.rom_addr, 0);
        chk("rst_sram_rd_en", bus1.sram_rd_en, 0);
        chk("rst_sram_addr", bus1.sram_addr, 0);
        tick();
        rst = 1'b0;
        #3;
        chk("idle_a_gnt", bus1.a_gnt, 0);
        tick();

        // Boot copy with A pending throughout and a second boot_start ignored.
        c0 = cyc;
        bus1.boot_start = 1'b1;
        push_copy(c0);
        tick();
        for (int k = 0; k <= N; k++) begin
            bus1.boot_start = (k == 1);
            #3;
            chk("copy_busy", bus1.boot_busy, 1);
            chk("copy_done", bus1.boot_done, 0);
            chk("copy_a_gnt", bus1.a_gnt, 0);
            tick();
        end
        bus1.boot_start = 1'b0;
        #3;
        chk("boot_len", cyc - c0, N + 2);
        chk("boot_busy_end", bus1.boot_busy, 0);
        chk("boot_done", bus1.boot_done, 1);
        chk("rom_addr_hold", bus1.rom_addr, N - 1);
        chk("pending_a_gnt", bus1.a_gnt, 1);
        push_rd(cyc + 1, 1'b0, 16'hA000);
        tick();
        bus1.a_req = 1'b0;

        foreach (vt[i]) begin
            bus1.a_req = vt[i].ar; bus1.a_we = vt[i].aw; bus1.a_addr = vt[i].aa; bus1.a_wdata = vt[i].ad;
            bus1.b_req = vt[i].br; bus1.b_we = vt[i].bw; bus1.b_addr = vt[i].ba; bus1.b_wdata = vt[i].bd;
            #3;
            chk($sformatf("v%0d_a_gnt", i), bus1.a_gnt, vt[i].ga);
            chk($sformatf("v%0d_b_gnt", i), bus1.b_gnt, vt[i].gb);
            exp_we = vt[i].ga ? vt[i].aw : (vt[i].gb ? vt[i].bw : 1'b0);
            chk($sformatf("v%0d_wr_en", i), bus1.sram_wr_en, exp_we);
            chk($sformatf("v%0d_rd_en", i), bus1.sram_rd_en, (vt[i].ga | vt[i].gb) & ~exp_we);
            if (vt[i].ga | vt[i].gb)
                chk($sformatf("v%0d_sram_addr", i), bus1.sram_addr, vt[i].ga ? vt[i].aa : vt[i].ba);
            if (exp_we)
                chk($sformatf("v%0d_wr_data", i), bus1.sram_wr_data, vt[i].ga ? vt[i].ad : vt[i].bd);
            if (vt[i].ga) begin
                if (vt[i].aw) shadow[int'(vt[i].aa)] = vt[i].ad;
                else push_rd(cyc + 1, 1'b0, shadow[int'(vt[i].aa)]);
            end
            if (vt[i].gb) begin
                if (vt[i].bw) shadow[int'(vt[i].ba)] = vt[i].bd;
                else push_rd(cyc + 1, 1'b1, shadow[int'(vt[i].ba)]);
            end
            tick();
        end
        {bus1.a_req, bus1.b_req} = '0;

        // Reload from RUN with a read granted in the same cycle, then reset mid-copy.
        c0 = cyc;
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 15'd5;
        bus1.boot_start = 1'b1;
        push_copy(c0);
        #3;
        chk("reload_b_gnt", bus1.b_gnt, 1);
        push_rd(cyc + 1, 1'b1, 16'h1234);
        tick();
        bus1.boot_start = 1'b0; bus1.b_req = 1'b0;
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 15'd3;
        #3;
        chk("reload_done_drop", bus1.boot_done, 0);
        chk("reload_busy", bus1.boot_busy, 1);
        chk("reload_a_gnt", bus1.a_gnt, 0);
        tick();
        #3;
        chk("reload_a_gnt2", bus1.a_gnt, 0);
        tick();
        wq1.delete();
        rst = 1'b1;
        #1;
        chk("async_busy", bus1.boot_busy, 0);
        chk("async_done", bus1.boot_done, 0);
        chk("async_wr_en", bus1.sram_wr_en, 0);
        chk("async_sram_addr", bus1.sram_addr, 0);
        chk("async_rom_addr", bus1.rom_addr, 0);
        chk("async_a_gnt", bus1.a_gnt, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        #3;
        chk("post_rst_done", bus1.boot_done, 0);
        chk("post_rst_busy", bus1.boot_busy, 0);
        chk("post_rst_a_gnt", bus1.a_gnt, 0);
        tick();

        // Fresh boot after reset releases the pending A read.
        c0 = cyc;
        bus1.boot_start = 1'b1;
        push_copy(c0);
        tick();
        bus1.boot_start = 1'b0;
        repeat (N + 1) begin
            #3;
            chk("reboot_busy", bus1.boot_busy, 1);
            tick();
        end
        #3;
        chk("reboot_done", bus1.boot_done, 1);
        chk("reboot_a_gnt", bus1.a_gnt, 1);
        push_rd(cyc + 1, 1'b0, 16'hA003);
        tick();
        bus1.a_req = 1'b0;
        tick();

        // Full 2^PW image: no address wrap, then RUN.
        c0 = cyc;
        bus2.boot_start = 1'b1;
        for (int i = 0; i < N2; i++)
            wq2.push_back('{c0 + 2 + i, PW'(i), 16'hA000 + 16'(i)});
        tick();
        bus2.boot_start = 1'b0;
        repeat (N2 + 1) begin
            #3;
            chk("big_busy", bus2.boot_busy, 1);
            chk("big_done_low", bus2.boot_done, 0);
            tick();
        end
        bus2.a_req = 1'b1; bus2.a_we = 1'b1; bus2.a_addr = 4'd9; bus2.a_wdata = 16'h5A5A;
        #3;
        chk("big_done", bus2.boot_done, 1);
        chk("big_busy_end", bus2.boot_busy, 0);
        chk("big_rom_hold", bus2.rom_addr, N2 - 1);
        chk("big_a_gnt", bus2.a_gnt, 1);
        tick();
        bus2.a_req = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
